// File: rtl/multi_cycle_mod_sub_pkg.sv
// rtl/multi_cycle_mod_sub_pkg.sv - curve parameters for the Fp arithmetic datapath
//
// Purpose: owns the field element type, its width and the field modulus P.
// Ports:   none (package).
package multi_cycle_mod_sub_pkg;

  localparam int FP_W = 61;

  typedef logic [FP_W-1:0] uint_fp_t;

  // Odd modulus with an irregular bit pattern so every limb of P differs.
  localparam uint_fp_t P = 61'h1D4F9A3C7B210E65;

endpackage

// File: rtl/mod_sub_limb.sv
// rtl/mod_sub_limb.sv - one limb stage of the pipelined modular subtractor
//
// Purpose: computes limb k of D = X - Y (borrow chain) and of E = D + P
//          (carry chain), registering both limbs and the chain outputs.
// Ports:   clk, rstn             clock, async active-low reset
//          x, y, p               operand limbs and modulus limb
//          borrow_in, carry_in   chain inputs from the previous limb (0 for limb 0)
//          d, e                  registered D and E limbs
//          borrow_out, carry_out registered chain outputs for the next limb
module mod_sub_limb #(
  parameter int LIMB_W  = 21,
  parameter bit IS_LAST = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic [LIMB_W-1:0] p,
  input  logic              borrow_in,
  input  logic              carry_in,
  output logic [LIMB_W-1:0] d,
  output logic [LIMB_W-1:0] e,
  output logic              borrow_out,
  output logic              carry_out
);

  // One extra bit: its value is the borrow out of this limb.
  logic [LIMB_W:0]   diff;
  logic [LIMB_W-1:0] e_next;

  assign diff = (LIMB_W+1)'(x) - (LIMB_W+1)'(y) - (LIMB_W+1)'(borrow_in);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d          <= '0;
      e          <= '0;
      borrow_out <= 1'b0;
    end else begin
      d          <= diff[LIMB_W-1:0];
      e          <= e_next;
      borrow_out <= diff[LIMB_W];
    end
  end

  // E is built on top of the D limb, so the E chain only ever carries
  // upward (0/1) and never needs a signed carry.
  if (IS_LAST) begin : g_last
    // Carry out of the top limb is the mod 2^W wrap and is discarded.
    assign e_next    = diff[LIMB_W-1:0] + p + LIMB_W'(carry_in);
    assign carry_out = 1'b0;
  end else begin : g_mid
    logic [LIMB_W:0] sum;

    assign sum    = (LIMB_W+1)'(diff[LIMB_W-1:0]) + (LIMB_W+1)'(p) + (LIMB_W+1)'(carry_in);
    assign e_next = sum[LIMB_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        carry_out <= 1'b0;
      end else begin
        carry_out <= sum[LIMB_W];
      end
    end
  end

endmodule

// File: rtl/multi_cycle_mod_sub.sv
// rtl/multi_cycle_mod_sub.sv - pipelined Z = (X - Y) mod P over latency limb stages
//
// Purpose: splits the operands into `latency` limbs, runs one limb per stage,
//          skews operand limbs in and deskews result limbs out so one
//          operation is accepted and one result produced every cycle.
// Ports:   clk, rstn   clock, async active-low reset
//          i_valid     X, Y valid this cycle
//          X, Y        minuend / subtrahend, both < P
//          o_valid     Z valid this cycle (latency cycles after i_valid)
//          Z           (X - Y) mod P
module multi_cycle_mod_sub
  import multi_cycle_mod_sub_pkg::*;
#(
  parameter int latency = 3
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     i_valid,
  input  uint_fp_t X,
  input  uint_fp_t Y,
  output logic     o_valid,
  output uint_fp_t Z
);

  localparam int W = FP_W;
  localparam int L = (W + latency - 1) / latency;

  // Chain inputs of each stage; index 0 is the constant start of both chains.
  wire [latency-1:0] borrow_in_w;
  wire [latency-1:0] carry_in_w;
  wire               borrow_final;
  logic              carry_unused;

  // Deskewed D and E, all limbs aligned to the last stage.
  wire [W-1:0]       d_all;
  wire [W-1:0]       e_all;

  logic [latency-1:0] vld_sr;

  assign borrow_in_w[0] = 1'b0;
  assign carry_in_w[0]  = 1'b0;

  for (genvar k = 0; k < latency; k++) begin : g_stage
    localparam int LO = k * L;
    localparam int HI = ((k + 1) * L > W) ? W : (k + 1) * L;
    localparam int WK = HI - LO;
    localparam int DS = latency - 1 - k;

    logic [WK-1:0] x_k;
    logic [WK-1:0] y_k;
    logic [WK-1:0] d_k;
    logic [WK-1:0] e_k;
    logic          b_out;
    logic          c_out;

    // Limb k of an operation must meet the chain outputs of limb k-1,
    // which arrive k cycles after the operation was sampled.
    if (k == 0) begin : g_noskew
      assign x_k = X[LO +: WK];
      assign y_k = Y[LO +: WK];
    end else begin : g_skew
      logic [WK-1:0] xs [k];
      logic [WK-1:0] ys [k];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int j = 0; j < k; j++) begin
            xs[j] <= '0;
            ys[j] <= '0;
          end
        end else begin
          xs[0] <= X[LO +: WK];
          ys[0] <= Y[LO +: WK];
          for (int j = 1; j < k; j++) begin
            xs[j] <= xs[j-1];
            ys[j] <= ys[j-1];
          end
        end
      end

      assign x_k = xs[k-1];
      assign y_k = ys[k-1];
    end

    mod_sub_limb #(
      .LIMB_W  (WK),
      .IS_LAST (k == latency - 1)
    ) u_limb (
      .clk        (clk),
      .rstn       (rstn),
      .x          (x_k),
      .y          (y_k),
      .p          (P[LO +: WK]),
      .borrow_in  (borrow_in_w[k]),
      .carry_in   (carry_in_w[k]),
      .d          (d_k),
      .e          (e_k),
      .borrow_out (b_out),
      .carry_out  (c_out)
    );

    if (k < latency - 1) begin : g_chain
      assign borrow_in_w[k+1] = b_out;
      assign carry_in_w[k+1]  = c_out;
    end else begin : g_final
      // Borrow out of the top limb is set exactly when X < Y.
      assign borrow_final = b_out;
      assign carry_unused = c_out;
    end

    // Hold early limbs until the top limb has been produced.
    if (DS == 0) begin : g_nodeskew
      assign d_all[LO +: WK] = d_k;
      assign e_all[LO +: WK] = e_k;
    end else begin : g_deskew
      logic [WK-1:0] ds [DS];
      logic [WK-1:0] es [DS];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int j = 0; j < DS; j++) begin
            ds[j] <= '0;
            es[j] <= '0;
          end
        end else begin
          ds[0] <= d_k;
          es[0] <= e_k;
          for (int j = 1; j < DS; j++) begin
            ds[j] <= ds[j-1];
            es[j] <= es[j-1];
          end
        end
      end

      assign d_all[LO +: WK] = ds[DS-1];
      assign e_all[LO +: WK] = es[DS-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= i_valid;
      for (int i = 1; i < latency; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  assign o_valid = vld_sr[latency-1];

  // X < Y wrapped below zero, so add P back (E); inputs < P mean one
  // correction is always enough. Every source is a reset flop, so Z = 0 in reset.
  assign Z = borrow_final ? e_all : d_all;

endmodule

// File: tb/tb_multi_cycle_mod_sub.sv
// tb/tb_multi_cycle_mod_sub.sv - scoreboard bench over several latency settings
module tb_multi_cycle_mod_sub;
  import multi_cycle_mod_sub_pkg::*;

  localparam int NL = 5;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 7;
      default: return 8;
    endcase
  endfunction

  typedef struct {
    uint_fp_t z;
    int       due;
  } exp_t;

  logic     clk = 1'b0;
  logic     rstn = 1'b0;
  logic     v_i = 1'b0;
  uint_fp_t x_i = '0;
  uint_fp_t y_i = '0;
  logic     ov [NL];
  uint_fp_t zo [NL];

  exp_t exp_q [NL][$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic uint_fp_t ref_sub(input uint_fp_t a, input uint_fp_t b);
    longint unsigned r;
    r = (64'(a) + 64'(P) - 64'(b)) % 64'(P);
    return uint_fp_t'(r);
  endfunction

  function automatic uint_fp_t rand_fp();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return P - 1;
      2:       return uint_fp_t'(1);
      default: return uint_fp_t'(r % 64'(P));
    endcase
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    multi_cycle_mod_sub #(.latency(lat_of(g))) u_dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_valid (v_i),
      .X       (x_i),
      .Y       (y_i),
      .o_valid (ov[g]),
      .Z       (zo[g])
    );

    always @(negedge clk) begin
      exp_t e;
      logic exp_v;
      if (!rstn) begin
        n_cmp++;
        if (ov[g] !== 1'b0 || zo[g] !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs lat=%0d: o_valid=%b Z=%h, required o_valid=0 Z=0",
                   lat_of(g), ov[g], zo[g]);
        end
      end else begin
        exp_v = (exp_q[g].size() > 0) && (exp_q[g][0].due == cyc);
        n_cmp++;
        if (ov[g] !== exp_v) begin
          n_fail++;
          $display("FAIL o_valid lat=%0d cyc=%0d: got %b, required %b", lat_of(g), cyc, ov[g], exp_v);
        end
        if (exp_v) begin
          e = exp_q[g].pop_front();
          n_cmp++;
          if (zo[g] !== e.z) begin
            n_fail++;
            $display("FAIL Z lat=%0d cyc=%0d: got %h, required %h", lat_of(g), cyc, zo[g], e.z);
          end
        end
      end
    end
  end

  // Called just after a rising edge; the operation is sampled on the next edge.
  task automatic issue(input uint_fp_t x, input uint_fp_t y, input uint_fp_t z_exp);
    exp_t e;
    x_i = x;
    y_i = y;
    v_i = 1'b1;
    for (int g = 0; g < NL; g++) begin
      e.z   = z_exp;
      e.due = cyc + lat_of(g);
      exp_q[g].push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      v_i = 1'b0;
      x_i = uint_fp_t'({$urandom, $urandom});
      y_i = uint_fp_t'({$urandom, $urandom});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int       pat [5];
    uint_fp_t xr;
    uint_fp_t yr;

    pat = '{1, 0, 1, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);

    // Directed edge values, back to back, with hand-derived results.
    issue(61'd5, 61'd5, 61'd0);
    issue(61'd0, P - 1, 61'd1);
    issue(P - 1, 61'd0, P - 1);
    issue(61'd1, 61'd2, P - 1);
    issue(61'd0, 61'd1, P - 1);
    issue(61'd0, 61'd0, 61'd0);
    issue(P - 1, P - 1, 61'd0);
    issue(P - 1, P - 2, 61'd1);
    issue(P - 2, P - 1, P - 1);
    idle(3);

    // Sparse valid pattern.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        if (pat[i] == 1) begin
          xr = rand_fp();
          yr = rand_fp();
          issue(xr, yr, ref_sub(xr, yr));
        end else begin
          idle(1);
        end
      end
    end
    idle(10);

    // Reset with operations in flight: all of them are discarded.
    for (int i = 0; i < 3; i++) begin
      xr = rand_fp();
      yr = rand_fp();
      issue(xr, yr, ref_sub(xr, yr));
    end
    rstn = 1'b0;
    v_i  = 1'b0;
    for (int g = 0; g < NL; g++) exp_q[g].delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(10);

    // Random regression with random gaps.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        xr = rand_fp();
        yr = ($urandom_range(0, 9) == 0) ? xr : rand_fp();
        issue(xr, yr, ref_sub(xr, yr));
      end else begin
        idle(1);
      end
    end
    idle(12);

    for (int g = 0; g < NL; g++) begin
      n_cmp++;
      if (exp_q[g].size() != 0) begin
        n_fail++;
        $display("FAIL drain lat=%0d: %0d results outstanding, required 0", lat_of(g), exp_q[g].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
